// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite constants, response codes and FSM state types.
package axi4_lite_pkg;

    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned AXIL_ADDR_W = 32;
    localparam int unsigned AXIL_STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA} rd_state_e;

endpackage

// File: rtl/axi4_lite_slv_regfile.sv
// NUM_REGS x 32 register array: one byte-strobed synchronous write port,
// one combinational read port; every entry resets to RESET_VAL.
module axi4_lite_slv_regfile
    import axi4_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000,
    localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [IDX_W-1:0]       waddr,
    input  logic [AXIL_DATA_W-1:0] wdata,
    input  logic [AXIL_STRB_W-1:0] wstrb,
    input  logic [IDX_W-1:0]       raddr,
    output logic [AXIL_DATA_W-1:0] rdata
);

    logic [AXIL_DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= RESET_VAL;
            end
        end else if (we) begin
            for (int unsigned i = 0; i < AXIL_STRB_W; i++) begin
                if (wstrb[i]) begin
                    regs[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers; independent write/read FSMs.
// Define AXIL_SLV_ERR_EN to answer out-of-range accesses with SLVERR.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AXIL_ADDR_W-1:0] awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [AXIL_DATA_W-1:0] wdata,
    input  logic [AXIL_STRB_W-1:0] wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [AXIL_ADDR_W-1:0] araddr,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [AXIL_DATA_W-1:0] rdata,
    output logic [1:0]             rresp,
    output logic                   rvalid,
    input  logic                   rready
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam logic [AXIL_ADDR_W-1:0] SPAN = AXIL_ADDR_W'(NUM_REGS * 4);

    wr_state_e wr_state;
    rd_state_e rd_state;

    logic [AXIL_ADDR_W-1:0] aw_lat;
    logic [AXIL_DATA_W-1:0] wd_lat;
    logic [AXIL_STRB_W-1:0] ws_lat;

    logic                   commit;
    logic [AXIL_ADDR_W-1:0] c_addr;
    logic [AXIL_DATA_W-1:0] c_data;
    logic [AXIL_STRB_W-1:0] c_strb;
    logic                   wr_in_range;
    logic                   rd_in_range;
    logic                   rf_we;
    logic [1:0]             wr_resp;
    logic [1:0]             rd_resp;
    logic [AXIL_DATA_W-1:0] rf_rdata;

    assign awready = !rst && (wr_state == W_IDLE || wr_state == W_DATA);
    assign wready  = !rst && (wr_state == W_IDLE || wr_state == W_ADDR);
    assign arready = !rst && (rd_state == R_IDLE);

    // Commit source: live channel inputs, or the half captured in W_ADDR/W_DATA.
    always_comb begin
        commit = 1'b0;
        c_addr = awaddr;
        c_data = wdata;
        c_strb = wstrb;
        case (wr_state)
            W_IDLE: commit = awvalid && wvalid;
            W_ADDR: begin
                commit = wvalid;
                c_addr = aw_lat;
            end
            W_DATA: begin
                commit = awvalid;
                c_data = wd_lat;
                c_strb = ws_lat;
            end
            default: commit = 1'b0;
        endcase
    end

    assign wr_in_range = (c_addr < SPAN);
    assign rd_in_range = (araddr < SPAN);
    assign rf_we       = !rst && commit && wr_in_range;

`ifdef AXIL_SLV_ERR_EN
    assign wr_resp = wr_in_range ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = rd_in_range ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    axi4_lite_slv_regfile #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (c_addr[2 +: IDX_W]),
        .wdata (c_data),
        .wstrb (c_strb),
        .raddr (araddr[2 +: IDX_W]),
        .rdata (rf_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            aw_lat   <= '0;
            wd_lat   <= '0;
            ws_lat   <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (commit) begin
                        bvalid   <= 1'b1;
                        bresp    <= wr_resp;
                        wr_state <= W_RESP;
                    end else if (awvalid) begin
                        aw_lat   <= awaddr;
                        wr_state <= W_ADDR;
                    end else if (wvalid) begin
                        wd_lat   <= wdata;
                        ws_lat   <= wstrb;
                        wr_state <= W_DATA;
                    end
                end
                W_ADDR, W_DATA: begin
                    if (commit) begin
                        bvalid   <= 1'b1;
                        bresp    <= wr_resp;
                        wr_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read data is captured before this edge's write lands, so a same-edge
    // write to the same register returns the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (arvalid) begin
                        rdata    <= rd_in_range ? rf_rdata : '0;
                        rresp    <= rd_resp;
                        rvalid   <= 1'b1;
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid   <= 1'b0;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed self-checking bench for axi4_lite_slave_regs (NUM_REGS=16, RESET_VAL=0).
module tb_axi4_lite_slave_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int checks = 0;
    int errors = 0;

`ifdef AXIL_SLV_ERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    axi4_lite_slave_regs #(
        .NUM_REGS  (16),
        .RESET_VAL (32'h0000_0000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] er);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        check({tag, ".rdy"}, {30'b0, awready, wready}, 32'h3);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check({tag, ".bvalid"}, {31'b0, bvalid}, 32'h1);
        check({tag, ".bresp"}, {30'b0, bresp}, {30'b0, er});
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, ".bdone"}, {31'b0, bvalid}, 32'h0);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] a, input logic [31:0] ed,
                            input logic [1:0] er);
        araddr = a; arvalid = 1'b1;
        check({tag, ".arready"}, {31'b0, arready}, 32'h1);
        tick();
        arvalid = 1'b0;
        check({tag, ".rvalid"}, {31'b0, rvalid}, 32'h1);
        check({tag, ".rdata"}, rdata, ed);
        check({tag, ".rresp"}, {30'b0, rresp}, {30'b0, er});
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check({tag, ".rdone"}, {31'b0, rvalid}, 32'h0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst.readies", {29'b0, awready, wready, arready}, 32'h0);
        check("rst.valids", {30'b0, bvalid, rvalid}, 32'h0);
        check("rst.rdata", rdata, 32'h0);
        check("rst.resps", {28'b0, bresp, rresp}, 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst.readies", {29'b0, awready, wready, arready}, 32'h7);

        // Aligned write then read
        axi_write("wr08", 32'h08, 32'hDEAD_BEEF, 4'hF, 2'b00);
        axi_read("rd08", 32'h08, 32'hDEAD_BEEF, 2'b00);

        // W first, AW three cycles later
        wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wfirst.rdy", {30'b0, awready, wready}, 32'h2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wfirst.wait", {30'b0, bvalid, wready}, 32'h0);
        end
        awaddr = 32'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst.bvalid", {30'b0, bresp, bvalid}, 32'h1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("wfirst.bdone", {31'b0, bvalid}, 32'h0);
        axi_read("rd04", 32'h04, 32'h1122_3344, 2'b00);

        // AW first, W two cycles later
        awaddr = 32'h0C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0; awaddr = 32'h0;
        check("awfirst.rdy", {30'b0, awready, wready}, 32'h1);
        tick();
        tick();
        check("awfirst.wait", {31'b0, bvalid}, 32'h0);
        wdata = 32'h5566_7788; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("awfirst.bvalid", {30'b0, bresp, bvalid}, 32'h1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read("rd0C", 32'h0C, 32'h5566_7788, 2'b00);
        axi_read("rd00_untouched", 32'h00, 32'h0, 2'b00);

        // Byte strobes
        axi_write("wr10", 32'h10, 32'hAABB_CCDD, 4'hF, 2'b00);
        axi_write("wr10_strb5", 32'h10, 32'h1122_3344, 4'b0101, 2'b00);
        axi_read("rd10_strb5", 32'h10, 32'hAA22_CC44, 2'b00);
        axi_write("wr10_strb0", 32'h10, 32'hFFFF_FFFF, 4'b0000, 2'b00);
        axi_read("rd10_strb0", 32'h10, 32'hAA22_CC44, 2'b00);

        // Unaligned address bits ignored
        axi_write("wr00", 32'h03, 32'h0BAD_F00D, 4'hF, 2'b00);

        // B backpressure while a read completes with rready toggling
        awaddr = 32'h14; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h00; arvalid = 1'b1;
        check("bp.arready", {31'b0, arready}, 32'h1);
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp.b", {29'b0, bvalid, bresp}, 32'h4);
            check("bp.awready", {30'b0, awready, wready}, 32'h0);
            check("bp.r", {31'b0, rvalid}, 32'h1);
            check("bp.rdata", rdata, 32'h0BAD_F00D);
            rready = (i == 3);
            tick();
        end
        rready = 1'b0;
        check("bp.rdone", {31'b0, rvalid}, 32'h0);
        check("bp.bstill", {29'b0, bvalid, bresp}, 32'h4);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bp.bdone", {31'b0, bvalid}, 32'h0);
        axi_read("rd14", 32'h14, 32'hCAFE_F00D, 2'b00);

        // Same-edge write and read of one register returns old value
        axi_write("wr18", 32'h18, 32'h1234_5678, 4'hF, 2'b00);
        awaddr = 32'h18; wdata = 32'h8765_4321; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h18; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same.rdata", rdata, 32'h1234_5678);
        check("same.valids", {30'b0, bvalid, rvalid}, 32'h3);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        axi_read("rd18_new", 32'h18, 32'h8765_4321, 2'b00);

        // Out-of-range at 0x40 (would alias register 0 if truncated)
        axi_write("wr40", 32'h40, 32'hFFFF_FFFF, 4'hF, OOR_RESP);
        axi_read("rd40", 32'h40, 32'h0, OOR_RESP);
        axi_write("wrhi", 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, OOR_RESP);
        axi_read("rd00_safe", 32'h00, 32'h0BAD_F00D, 2'b00);

        // Reset while in W_RESP and R_DATA
        awaddr = 32'h1C; wdata = 32'h7777_7777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("mid.valids", {30'b0, bvalid, rvalid}, 32'h3);
        rst = 1'b1;
        tick();
        check("mid.valids_rst", {30'b0, bvalid, rvalid}, 32'h0);
        check("mid.rdata_rst", rdata, 32'h0);
        check("mid.readies_rst", {29'b0, awready, wready, arready}, 32'h0);
        rst = 1'b0;
        #1;
        check("mid.readies", {29'b0, awready, wready, arready}, 32'h7);
        axi_read("rst_rd08", 32'h08, 32'h0, 2'b00);
        axi_read("rst_rd10", 32'h10, 32'h0, 2'b00);
        axi_read("rst_rd1C", 32'h1C, 32'h0, 2'b00);
        axi_read("rst_rd00", 32'h00, 32'h0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
- AXI4-Lite slave endpoint: the responder side of the team's axi4_lite_if.
- Exposes a bank of NUM_REGS 32-bit read/write registers to an AXI4-Lite master.
- Independent write and read FSMs; byte-strobed writes; one outstanding transaction per direction.
- Ports match the slave modport signal names, so a thin wrapper binds it directly to axi4_lite_if.slave.

Parameters:
- NUM_REGS, 16, register count; power of two, 2..256; byte span is NUM_REGS*4 starting at address 0.
- RESET_VAL, 32'h0000_0000, reset value loaded into every register.

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  reset, synchronous and active-high.
- awaddr input 32 / awvalid input 1 / awready output 1  write address channel.
- wdata input 32 / wstrb input 4 / wvalid input 1 / wready output 1  write data channel.
- bresp output 2 / bvalid output 1 / bready input 1  write response channel.
- araddr input 32 / arvalid input 1 / arready output 1  read address channel.
- rdata output 32 / rresp output 2 / rvalid output 1 / rready input 1  read data channel.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Write FSM goes to W_IDLE; read FSM goes to R_IDLE.
  - All registers load RESET_VAL.
  - bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=0.
  - While rst is high, awready, wready and arready are forced to 0.
  - A reset mid-transaction drops any pending response. No partial register update occurs.
- Ready timing: awready, wready and arready are Moore decodes of the FSM state. There is no combinational path from any valid to any ready.
- Address decode:
  - Register index = addr[2 +: log2(NUM_REGS)]; addr[1:0] are ignored.
  - An address is in range when addr < NUM_REGS*4, compared on all 32 bits.
- Write FSM:
  - W_IDLE: awready=1, wready=1.
    - awvalid and wvalid both high: commit write at this edge -> W_RESP.
    - awvalid only: latch awaddr -> W_ADDR.
    - wvalid only: latch wdata and wstrb -> W_DATA.
  - W_ADDR: awready=0, wready=1. On wvalid: commit write using the latched address -> W_RESP.
  - W_DATA: awready=1, wready=0. On awvalid: commit write using the latched data -> W_RESP.
  - W_RESP: awready=0, wready=0, bvalid=1, bresp held stable. On bready: -> W_IDLE, bvalid=0 at the next edge.
- Commit rules:
  - For each i with wstrb[i]=1, byte i of the target register takes wdata[8i+7:8i]; other bytes are unchanged.
  - wstrb=4'b0000 is a legal no-op and returns OKAY.
  - The register value is visible to reads starting the cycle after commit.
  - bvalid rises the cycle after commit.
- Read FSM:
  - R_IDLE: arready=1. On arvalid: rdata/rresp are registered from the decoded register -> R_DATA. rvalid=1 the next cycle (read latency 1).
  - R_DATA: arready=0; rdata, rresp and rvalid are held stable until rready. On rready: -> R_IDLE.
  - Peak throughput: one read per 2 cycles.
- Simultaneous read and write commit to the same register at the same edge: the read returns the old value.
- Channels are fully independent; a stalled bready never blocks reads, and a stalled rready never blocks writes.
- Master holding valid without ready is legal; the slave never drops an asserted response.

Optional Feature:
- Macro: AXIL_SLV_ERR_EN.
- Defined:
  - Out-of-range write: no register changes; bresp=2'b10 (SLVERR).
  - Out-of-range read: rdata=32'h0, rresp=2'b10.
- Undefined:
  - Out-of-range write: silently ignored, bresp=OKAY.
  - Out-of-range read: rdata=0, rresp=OKAY.
- Handshake timing is identical in both builds.

Decomposition:
- Package axi4_lite_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - AXIL_DATA_W=32, AXIL_ADDR_W=32, AXIL_STRB_W=4.
  - Enum wr_state_e {W_IDLE, W_ADDR, W_DATA, W_RESP}.
  - Enum rd_state_e {R_IDLE, R_DATA}.
- One sub-module: axi4_lite_slv_regfile. It is a NUM_REGS x 32 array with one byte-strobed synchronous write port and one read port, and resets to RESET_VAL. The top level holds both FSMs, address decode and response logic.

Test Plan:
- Aligned write then read: write awaddr=0x08, wdata=0xDEADBEEF, wstrb=0xF (AW and W in the same cycle) -> bvalid next cycle, bresp=0. Then read araddr=0x08 -> rvalid one cycle after the AR handshake, rdata=0xDEADBEEF, rresp=0.
- Split AW/W ordering:
  - W first (wdata=0x11223344) then AW 3 cycles later at 0x04 -> W_DATA state holds wready=0; one B response.
  - Repeat with AW first to 0x0C -> readback matches in both cases.
- Byte strobes: reg 0x10=0xAABBCCDD, then write 0x11223344 with wstrb=0b0101 -> readback 0xAA22CC44. A write with wstrb=0 -> value unchanged, bresp=OKAY.
- Backpressure and concurrency:
  - Hold bready=0 for 5 cycles -> bvalid and bresp stable, awready=0.
  - Meanwhile a read of 0x00 completes with rready toggling -> rdata stable while rready=0.
  - Same-edge write/read to one register -> read returns the old value.
- Out-of-range: write and read at 0x40 (NUM_REGS=16).
  - AXIL_SLV_ERR_EN defined -> bresp=rresp=2'b10, rdata=0, no register altered.
  - Undefined -> both responses 2'b00.
- Reset mid-operation: assert rst while in W_RESP and R_DATA -> next cycle bvalid=rvalid=0, all registers =RESET_VAL. After rst deasserts -> awready=wready=arready=1.
